// File: rtl/regfile_write_arbiter_if.sv
// Writeback-side bundle of the register file write arbiter: two requesters,
// the clear sequencer controls and the register file write port.
interface regfile_write_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;
    logic                  clear_req;
    logic                  clear_busy;
    logic [ADDR_WIDTH-1:0] rf_write_addr;
    logic [DATA_WIDTH-1:0] rf_write_data;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        output clear_req,
        input  clear_busy,
        input  rf_write_addr, rf_write_data
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        input  clear_req,
        output clear_busy,
        output rf_write_addr, rf_write_data
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register file write port, with a one-register-per-
// cycle clear sweep of R1..NUM_REGS-1. Address 0 on the port is the idle write.
module regfile_write_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_write_arbiter_if.slave bus
);
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  rr_last_q;
    logic                  busy_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  grant0_d;
    logic                  grant1_d;

    // Grant selection; rr_last_q holds the id of the most recent winner.
    always_comb begin
        grant0_d = 1'b0;
        grant1_d = 1'b0;
        if (rst) begin
            grant0_d = 1'b0;
            grant1_d = 1'b0;
        end else if ((state_q == IDLE) && !bus.clear_req) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0_d = rr_last_q;
                grant1_d = ~rr_last_q;
            end else begin
                grant0_d = bus.req0_valid;
                grant1_d = bus.req1_valid;
            end
        end else begin
            grant0_d = 1'b0;
            grant1_d = 1'b0;
        end
    end

    assign bus.req0_ready    = grant0_d;
    assign bus.req1_ready    = grant1_d;
    assign bus.clear_busy    = busy_q;
    assign bus.rf_write_addr = addr_q;
    assign bus.rf_write_data = data_q;

    // Sequencer state, arbitration history and the registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rr_last_q <= 1'b1;
            busy_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.clear_req) begin
                        state_q <= CLEAR;
                        cnt_q   <= ADDR_WIDTH'(1);
                        busy_q  <= 1'b1;
                        addr_q  <= '0;
                        data_q  <= '0;
                    end else if (grant0_d) begin
                        addr_q    <= bus.req0_addr;
                        data_q    <= bus.req0_data;
                        rr_last_q <= 1'b0;
                    end else if (grant1_d) begin
                        addr_q    <= bus.req1_addr;
                        data_q    <= bus.req1_data;
                        rr_last_q <= 1'b1;
                    end else begin
                        addr_q <= '0;
                        data_q <= '0;
                    end
                end
                CLEAR: begin
                    addr_q <= cnt_q;
                    data_q <= '0;
                    // Exit on the last register so the counter never wraps.
                    if (cnt_q == LAST_REG) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    addr_q  <= '0;
                    data_q  <= '0;
                end
            endcase
        end
    end
endmodule
